// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 input loader.
package aes_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LD_KEY    = 3'd1,
    LD_PT     = 3'd2,
    LAUNCH    = 3'd3,
    WAIT_DONE = 3'd4
  } ldr_state_t;

  // True in the states where the loader accepts stream words.
  function automatic logic accepts_words(input ldr_state_t st);
    case (st)
      IDLE, LD_KEY, LD_PT: accepts_words = 1'b1;
      default:             accepts_words = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/aes_word_shifter.sv
// 128-bit register that shifts in one stream word per load, first word ending at the MSB.
module aes_word_shifter
  import aes_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WORD_W-1:0]    din,
  output logic [AES_BLK_W-1:0] q
);

  logic [AES_BLK_W-1:0] q_r;
  logic [AES_BLK_W-1:0] shift_s;

  generate
    if (WORD_W == AES_BLK_W) begin : g_full
      assign shift_s = din;
    end else begin : g_part
      assign shift_s = {q_r[AES_BLK_W-WORD_W-1:0], din};
    end
  endgenerate

  // Shift a new word in on each load; hold otherwise.
  always_ff @(posedge CLK) begin
    if (rst) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= shift_s;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/aes_in_loader.sv
// Assembles key and plaintext from a word stream and launches one AES block at a time.
module aes_in_loader
  import aes_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [WORD_W-1:0]    s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 new_key,
  input  logic                 Busy,
  input  logic                 Done,
  output logic                 Valid,
  output logic [AES_BLK_W-1:0] Key,
  output logic [AES_BLK_W-1:0] Plain_Txt,
  output logic                 key_loaded,
  output logic                 launch_err
);

  localparam int N_WORDS = AES_BLK_W / WORD_W;
  localparam int CNT_W   = $clog2(N_WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_WORDS - 1);

  ldr_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             s_ready_r;
  logic             valid_r;
  logic             key_loaded_r;
  logic             launch_err_r;
  logic [1:0]       chk_r;
  logic             busy_seen_r;

  logic beat_s;
  logic take_key_s;
  logic key_ld_s;
  logic pt_ld_s;

  // Decode which register the current beat feeds.
  always_comb begin
    beat_s     = s_valid && s_ready_r;
    take_key_s = new_key || !key_loaded_r;
    key_ld_s   = 1'b0;
    pt_ld_s    = 1'b0;
    case (state_r)
      IDLE: begin
        key_ld_s = beat_s && take_key_s;
        pt_ld_s  = beat_s && !take_key_s;
      end
      LD_KEY:  key_ld_s = beat_s;
      LD_PT:   pt_ld_s  = beat_s;
      default: begin
        key_ld_s = 1'b0;
        pt_ld_s  = 1'b0;
      end
    endcase
  end

  // Loader FSM with beat counter and registered handshake/launch outputs.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      s_ready_r    <= 1'b0;
      valid_r      <= 1'b0;
      key_loaded_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          s_ready_r <= 1'b1;
          if (beat_s) begin
            if (take_key_s) begin
              // A partial key must never look valid, so drop the flag now.
              key_loaded_r <= (N_WORDS == 1);
              state_r      <= (N_WORDS == 1) ? LD_PT : LD_KEY;
              cnt_r        <= (N_WORDS == 1) ? CNT_W'(0) : CNT_W'(1);
            end else if (N_WORDS == 1) begin
              state_r   <= LAUNCH;
              valid_r   <= 1'b1;
              s_ready_r <= 1'b0;
              cnt_r     <= '0;
            end else begin
              state_r <= LD_PT;
              cnt_r   <= CNT_W'(1);
            end
          end
        end
        LD_KEY: begin
          if (beat_s) begin
            if (cnt_r == LAST_BEAT) begin
              key_loaded_r <= 1'b1;
              state_r      <= LD_PT;
              cnt_r        <= '0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        LD_PT: begin
          if (beat_s) begin
            if (cnt_r == LAST_BEAT) begin
              state_r   <= LAUNCH;
              valid_r   <= 1'b1;
              s_ready_r <= 1'b0;
              cnt_r     <= '0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        LAUNCH: begin
          state_r   <= WAIT_DONE;
          s_ready_r <= 1'b0;
        end
        WAIT_DONE: begin
          if (Done) begin
            state_r   <= IDLE;
            s_ready_r <= 1'b1;
            cnt_r     <= '0;
          end else begin
            s_ready_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          s_ready_r <= 1'b0;
          cnt_r     <= '0;
        end
      endcase
    end
  end

  // Watch the two cycles after Valid for Busy; flag a sticky error if it never came.
  always_ff @(posedge CLK) begin
    if (rst) begin
      chk_r        <= 2'd0;
      busy_seen_r  <= 1'b0;
      launch_err_r <= 1'b0;
    end else begin
      case (chk_r)
        2'd0: begin
          if (valid_r) begin
            chk_r       <= 2'd1;
            busy_seen_r <= 1'b0;
          end else begin
            chk_r <= 2'd0;
          end
        end
        2'd1: begin
          busy_seen_r <= Busy;
          chk_r       <= 2'd2;
        end
        2'd2: begin
          if (!busy_seen_r && !Busy) begin
            launch_err_r <= 1'b1;
          end else begin
            launch_err_r <= launch_err_r;
          end
          chk_r <= 2'd0;
        end
        default: chk_r <= 2'd0;
      endcase
    end
  end

  aes_word_shifter #(.WORD_W(WORD_W)) u_key_sh (
    .CLK  (CLK),
    .rst  (rst),
    .load (key_ld_s),
    .din  (s_data),
    .q    (Key)
  );

  aes_word_shifter #(.WORD_W(WORD_W)) u_pt_sh (
    .CLK  (CLK),
    .rst  (rst),
    .load (pt_ld_s),
    .din  (s_data),
    .q    (Plain_Txt)
  );

  assign s_ready    = s_ready_r;
  assign Valid      = valid_r;
  assign key_loaded = key_loaded_r;
  assign launch_err = launch_err_r;

endmodule
